// File: rtl/camera_basis_rotator.sv
// Camera basis (U, V, W) held in signed Q2.FRAC registers; each accepted key rotates two
// basis vectors about the third, one component per cycle, then commits all nine at once.
module camera_basis_rotator #(
    parameter int W     = 24,
    parameter int FRAC  = W - 2,
    parameter int COS_Q = 2965821,
    parameter int SIN_Q = 2965821
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          key,
    input  logic                key_valid,
    output logic                key_ready,
    output logic signed [W-1:0] U_x,
    output logic signed [W-1:0] U_y,
    output logic signed [W-1:0] U_z,
    output logic signed [W-1:0] V_x,
    output logic signed [W-1:0] V_y,
    output logic signed [W-1:0] V_z,
    output logic signed [W-1:0] W_x,
    output logic signed [W-1:0] W_y,
    output logic signed [W-1:0] W_z,
    output logic                upd_valid,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, CALC0, CALC1, CALC2, COMMIT} state_t;
    typedef enum logic [1:0] {PIV_V, PIV_W, PIV_U} pair_t;

    localparam logic signed [W-1:0]   ONE     = W'(64'sd1 <<< (W - 2));
    localparam logic signed [W-1:0]   COEF_C  = W'(COS_Q);
    localparam logic signed [W-1:0]   COEF_S  = W'(SIN_Q);
    localparam logic signed [2*W:0]   RND     = (2*W+1)'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [2*W:0]   SAT_MAX = (2*W+1)'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [2*W:0]   SAT_MIN = -SAT_MAX - (2*W+1)'(1);

    function automatic logic signed [2*W:0] prod(input logic signed [W-1:0] x,
                                                 input logic signed [W-1:0] y);
        logic signed [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        return (2*W+1)'(p);
    endfunction

    function automatic logic signed [W-1:0] sat_round(input logic signed [2*W:0] acc);
        logic signed [2*W:0] r;
        r = (acc + RND) >>> FRAC;
        if (r > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return r[W-1:0];
    endfunction

    state_t              state;
    pair_t               pair;
    logic                cw;
    logic signed [W-1:0] bu [3];
    logic signed [W-1:0] bv [3];
    logic signed [W-1:0] bw [3];
    logic signed [W-1:0] su [3];
    logic signed [W-1:0] sv [3];
    logic signed [W-1:0] sw [3];
    logic [1:0]          idx;
    logic signed [W-1:0] a_cur, b_cur, s_cur, na, nb;

    // Operands come from the visible basis, which stays frozen until COMMIT.
    always_comb begin
        case (state)
            CALC1:   idx = 2'd1;
            CALC2:   idx = 2'd2;
            default: idx = 2'd0;
        endcase
        a_cur = bu[idx];
        b_cur = bw[idx];
        case (pair)
            PIV_W:   b_cur = bv[idx];
            PIV_U:   a_cur = bv[idx];
            default: ;
        endcase
        s_cur = cw ? COEF_S : -COEF_S;
        na    = sat_round(prod(COEF_C, a_cur) - prod(s_cur, b_cur));
        nb    = sat_round(prod(s_cur, a_cur) + prod(COEF_C, b_cur));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pair      <= PIV_V;
            cw        <= 1'b0;
            upd_valid <= 1'b0;
            bu        <= '{ONE, '0, '0};
            bv        <= '{'0, ONE, '0};
            bw        <= '{'0, '0, ONE};
            su        <= '{ONE, '0, '0};
            sv        <= '{'0, ONE, '0};
            sw        <= '{'0, '0, ONE};
        end else begin
            upd_valid <= 1'b0;
            case (state)
                IDLE: if (key_valid) begin
                    su <= bu;
                    sv <= bv;
                    sw <= bw;
                    case (key)
                        4'd6, 4'd7: begin
                            pair  <= PIV_V;
                            cw    <= ~key[0];
                            state <= CALC0;
                        end
                        4'd8, 4'd9: begin
                            pair  <= PIV_W;
                            cw    <= ~key[0];
                            state <= CALC0;
                        end
                        4'd10, 4'd11: begin
                            pair  <= PIV_U;
                            cw    <= ~key[0];
                            state <= CALC0;
                        end
                        4'd12: begin
                            su    <= '{ONE, '0, '0};
                            sv    <= '{'0, ONE, '0};
                            sw    <= '{'0, '0, ONE};
                            state <= COMMIT;
                        end
                        default: ;
                    endcase
                end
                CALC0, CALC1, CALC2: begin
                    case (pair)
                        PIV_V: begin
                            su[idx] <= na;
                            sw[idx] <= nb;
                        end
                        PIV_W: begin
                            su[idx] <= na;
                            sv[idx] <= nb;
                        end
                        default: begin
                            sv[idx] <= na;
                            sw[idx] <= nb;
                        end
                    endcase
                    state <= (state == CALC0) ? CALC1 : (state == CALC1) ? CALC2 : COMMIT;
                end
                COMMIT: begin
                    bu        <= su;
                    bv        <= sv;
                    bw        <= sw;
                    upd_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign U_x = bu[0];
    assign U_y = bu[1];
    assign U_z = bu[2];
    assign V_x = bv[0];
    assign V_y = bv[1];
    assign V_z = bv[2];
    assign W_x = bw[0];
    assign W_y = bw[1];
    assign W_z = bw[2];

endmodule

// File: tb/tb_camera_basis_rotator.sv
// Bench for camera_basis_rotator: a behavioural basis/latency model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_camera_basis_rotator;

    localparam int     W    = 24;
    localparam int     FRAC = 22;
    localparam longint ONE  = 4194304;
    localparam longint C    = 2965821;
    localparam longint S    = 2965821;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] key = 4'd0;
    logic key_valid = 1'b0;
    logic key_ready, upd_valid, busy;
    logic signed [W-1:0] U_x, U_y, U_z, V_x, V_y, V_z, W_x, W_y, W_z;

    camera_basis_rotator #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .U_x(U_x), .U_y(U_y), .U_z(U_z), .V_x(V_x), .V_y(V_y), .V_z(V_z),
        .W_x(W_x), .W_y(W_y), .W_z(W_z), .upd_valid(upd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: mb[vec][comp] with vec 0=U, 1=V, 2=W; mp is the pending result.
    longint mb [3][3];
    longint mp [3][3];
    int     m_cnt;
    bit     m_upd;
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    int     upd_seen = 0;
    bit     run_cmp = 1'b0;

    function automatic longint rnd_sat(longint acc);
        longint r;
        r = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        if (r > 8388607) r = 8388607;
        if (r < -8388608) r = -8388608;
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < 3; i++)
                mb[v][i] = (v == i) ? ONE : 0;
        m_cnt = 0;
        m_upd = 1'b0;
    endtask

    task automatic rotate(input int a, input int b, input bit cwise);
        longint s;
        s = cwise ? S : -S;
        for (int i = 0; i < 3; i++) begin
            mp[a][i] = rnd_sat(C * mb[a][i] - s * mb[b][i]);
            mp[b][i] = rnd_sat(s * mb[a][i] + C * mb[b][i]);
        end
        m_cnt = 4;
    endtask

    task automatic model_edge(output bit acc);
        acc = key_valid && (m_cnt == 0) && rst_n;
        m_upd = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                mb = mp;
                m_upd = 1'b1;
            end
        end else if (acc) begin
            mp = mb;
            case (key)
                4'd6, 4'd7:   rotate(0, 2, !key[0]);
                4'd8, 4'd9:   rotate(0, 1, !key[0]);
                4'd10, 4'd11: rotate(1, 2, !key[0]);
                4'd12: begin
                    for (int v = 0; v < 3; v++)
                        for (int i = 0; i < 3; i++)
                            mp[v][i] = (v == i) ? ONE : 0;
                    m_cnt = 1;
                end
                default: ;
            endcase
        end
    endtask

    function automatic longint dut_comp(int v, int i);
        logic signed [W-1:0] x;
        case (v * 3 + i)
            0: x = U_x; 1: x = U_y; 2: x = U_z;
            3: x = V_x; 4: x = V_y; 5: x = V_z;
            6: x = W_x; 7: x = W_y; default: x = W_z;
        endcase
        return longint'(x);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d +/- %0d", name, cyc, act, exp, tol);
        end
    endtask

    task automatic chk_reset_basis(input string name, input longint tol);
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < 3; i++)
                chk_tol($sformatf("%s_%0d%0d", name, v, i), dut_comp(v, i), (v == i) ? ONE : 0, tol);
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int v = 0; v < 3; v++)
                for (int i = 0; i < 3; i++)
                    chk($sformatf("basis_%0d%0d", v, i), dut_comp(v, i), mb[v][i]);
            chk("upd_valid", longint'(upd_valid), longint'(m_upd));
            chk("key_ready", longint'(key_ready), longint'(m_cnt == 0));
            chk("busy", longint'(busy), longint'(m_cnt != 0));
            if (upd_valid) upd_seen++;
        end
    end

    task automatic step(output bit acc);
        @(posedge clk);
        model_edge(acc);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        key_valid = 1'b0;
        repeat (n) step(a);
    endtask

    task automatic send_key(input logic [3:0] k, output int acc_cyc);
        bit a;
        key = k;
        key_valid = 1'b1;
        acc_cyc = -1;
        for (int n = 0; n < 40; n++) begin
            step(a);
            if (a) begin
                acc_cyc = cyc;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, t1, u0;
        model_reset();
        #12;
        rst_n = 1'b1;
        chk_reset_basis("rst_basis", 0);
        chk("rst_upd", longint'(upd_valid), 0);
        chk("rst_ready", longint'(key_ready), 1);
        run_cmp = 1'b1;
        idle(2);

        // Key 6 from reset.
        u0 = upd_seen;
        send_key(6, t0);
        idle(5);
        chk("k6_Ux", longint'(U_x), 2965821);
        chk("k6_Uy", longint'(U_y), 0);
        chk("k6_Uz", longint'(U_z), -2965821);
        chk("k6_Wx", longint'(W_x), 2965821);
        chk("k6_Wz", longint'(W_z), 2965821);
        chk("k6_Vy", longint'(V_y), ONE);
        chk("k6_pulses", upd_seen - u0, 1);

        send_key(12, t0);
        idle(3);
        chk_reset_basis("home", 0);

        // Key 6 then key 7 with valid held.
        u0 = upd_seen;
        send_key(6, t0);
        send_key(7, t1);
        chk("k67_gap", t1 - t0, 5);
        idle(6);
        chk_reset_basis("k67_back", 1);
        chk("k67_pulses", upd_seen - u0, 2);

        // Eight presses of key 10.
        send_key(12, t0);
        idle(2);
        for (int n = 0; n < 8; n++) begin
            send_key(10, t0);
            idle(5);
            chk("k10_Ux", longint'(U_x), ONE);
            chk("k10_Uy", longint'(U_y), 0);
            chk("k10_Uz", longint'(U_z), 0);
        end
        chk_reset_basis("k10_loop", 8);

        // Discarded key and HOME after rotation.
        u0 = upd_seen;
        send_key(3, t0);
        idle(4);
        chk("k3_pulses", upd_seen - u0, 0);
        send_key(9, t0);
        idle(5);
        send_key(12, t0);
        key_valid = 1'b0;
        begin
            bit a;
            step(a);
        end
        chk("home_upd", longint'(upd_valid), 1);
        chk("home_Ux", longint'(U_x), ONE);
        chk("home_Vx", longint'(V_x), 0);
        idle(2);

        // Reset in the middle of a key 8 rotation.
        u0 = upd_seen;
        send_key(8, t0);
        idle(2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_basis("midrst", 0);
        chk("midrst_upd", longint'(upd_valid), 0);
        chk("midrst_ready", longint'(key_ready), 1);
        idle(1);
        rst_n = 1'b1;
        idle(4);
        chk("midrst_pulses", upd_seen - u0, 0);
        send_key(9, t0);
        send_key(3, t1);
        chk("k9_gap", t1 - t0, 5);
        idle(2);

        // Randomized keys, gaps and occasional resets.
        for (int n = 0; n < 120; n++) begin
            send_key(4'($urandom_range(0, 15)), t0);
            if ($urandom_range(0, 24) == 0)
                pulse_reset();
            else
                idle($urandom_range(0, 6));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
